// File: rtl/transfer_sequencer_pkg.sv
// Shared encodings for the UART->FIFO->SD transfer sequencer: state codes,
// fault codes and small helpers used by the FSM and its timeout counter.
package transfer_sequencer_pkg;

    localparam int TMO_W = 24;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WAIT_SD = 4'd1,
        ST_RECEIVE = 4'd2,
        ST_DRAIN   = 4'd3,
        ST_FLUSH   = 4'd4,
        ST_DONE    = 4'd5,
        ST_ERROR   = 4'd15
    } state_e;

    localparam logic [3:0] ERR_NONE    = 4'h0;
    localparam logic [3:0] ERR_SD_INIT = 4'hA;
    localparam logic [3:0] ERR_TIMEOUT = 4'hE;
    localparam logic [3:0] ERR_FLUSH   = 4'hF;

    // States in which the sequencer is waiting on an external stage.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_WAIT_SD) || (s == ST_RECEIVE) ||
               (s == ST_DRAIN)   || (s == ST_FLUSH);
    endfunction

    function automatic logic [3:0] timeout_code(input state_e s);
        case (s)
            ST_WAIT_SD: return ERR_SD_INIT;
            ST_FLUSH:   return ERR_FLUSH;
            default:    return ERR_TIMEOUT;
        endcase
    endfunction

endpackage

// File: rtl/transfer_sequencer_timeout.sv
// Stall detector: counts enabled cycles and flags expiry on the last allowed
// cycle. A zero TIMEOUT_CYCLES disables expiry entirely.
module seq_timeout_counter
    import transfer_sequencer_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd600000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] LAST = TIMEOUT_CYCLES - 24'd1;

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Expiry must not depend on clear_i: clear is derived from the FSM next state.
    assign expired_o = (TIMEOUT_CYCLES != 24'd0) && enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/transfer_sequencer.sv
// Sequencer for the UART->FIFO->SD datapath: gates the receive and drain
// enables, tracks drained bytes, and reports state/fault codes for display.
module transfer_sequencer
    import transfer_sequencer_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd600000,
    parameter int               CNT_W          = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             sd_init_done,
    input  logic             com_finish,
    input  logic [3:0]       com_error,
    input  logic             fifo_empty,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic             out_finish,
    input  logic             sd_write_done,
    output logic             com_enable,
    output logic             out_enable,
    output logic             busy,
    output logic             done,
    output logic [3:0]       err_code,
    output logic [3:0]       state_code,
    output logic [15:0]      byte_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       err_q, err_d;
    logic             restart;
    logic [CNT_W-1:0] fifo_cnt_q;
    logic [15:0]      bytes_q;
    logic             com_en_q, out_en_q, busy_q, done_q;
    logic             tmo_expired;
    logic             byte_inc;

    seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk),
        .rst_ni   (reset),
        .clear_i  (state_d != state_q),
        .enable_i (is_wait_state(state_q)),
        .expired_o(tmo_expired)
    );

    // A byte leaves the FIFO when occupancy drops by exactly one in DRAIN.
    assign byte_inc = (state_q == ST_DRAIN) && (fifo_cnt_q != '0) &&
                      (fifo_count == fifo_cnt_q - CNT_ONE);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        restart = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else if ((state_q == ST_RECEIVE) && (com_error != 4'h0)) begin
            state_d = ST_ERROR;
            err_d   = com_error;
        end else if (tmo_expired) begin
            state_d = ST_ERROR;
            err_d   = timeout_code(state_q);
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_d = ST_WAIT_SD;
                        err_d   = ERR_NONE;
                        restart = 1'b1;
                    end
                end
                ST_WAIT_SD: if (sd_init_done) state_d = ST_RECEIVE;
                ST_RECEIVE: if (com_finish) state_d = ST_DRAIN;
                ST_DRAIN:   if (out_finish && fifo_empty) state_d = ST_FLUSH;
                ST_FLUSH:   if (sd_write_done) state_d = ST_DONE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            fifo_cnt_q <= '0;
            bytes_q    <= '0;
            com_en_q   <= 1'b0;
            out_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            fifo_cnt_q <= fifo_count;
            com_en_q   <= (state_d == ST_RECEIVE);
            out_en_q   <= (state_d == ST_DRAIN);
            busy_q     <= is_wait_state(state_d);
            done_q     <= (state_d == ST_DONE);
            if (restart) begin
                bytes_q <= '0;
            end else if (byte_inc && (bytes_q != 16'hFFFF)) begin
                bytes_q <= bytes_q + 16'd1;
            end
        end
    end

    assign com_enable = com_en_q;
    assign out_enable = out_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_code   = err_q;
    assign state_code = state_q;
    assign byte_count = bytes_q;

endmodule

// File: tb/tb_transfer_sequencer.sv
// Directed bench for transfer_sequencer: a vector table for the main flow plus
// hand-written sequences for reset, timeout and abort corner cases.
module tb_transfer_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start, abort, sd_init_done, com_finish, fifo_empty, out_finish, sd_write_done;
    logic [3:0]  com_error;
    logic [9:0]  fifo_count;

    logic        com_enable, out_enable, busy, done;
    logic [3:0]  err_code, state_code;
    logic [15:0] byte_count;

    logic        t_com_enable, t_out_enable, t_busy, t_done;
    logic [3:0]  t_err_code, t_state_code;
    logic [15:0] t_byte_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    transfer_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sd_init_done(sd_init_done), .com_finish(com_finish), .com_error(com_error),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .out_finish(out_finish),
        .sd_write_done(sd_write_done), .com_enable(com_enable), .out_enable(out_enable),
        .busy(busy), .done(done), .err_code(err_code), .state_code(state_code),
        .byte_count(byte_count)
    );

    transfer_sequencer #(.TIMEOUT_CYCLES(24'd16)) dut_t (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sd_init_done(sd_init_done), .com_finish(com_finish), .com_error(com_error),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .out_finish(out_finish),
        .sd_write_done(sd_write_done), .com_enable(t_com_enable), .out_enable(t_out_enable),
        .busy(t_busy), .done(t_done), .err_code(t_err_code), .state_code(t_state_code),
        .byte_count(t_byte_count)
    );

    typedef struct {
        logic [3:0]  ctl;      // start, abort, sd_init_done, com_finish
        logic [3:0]  cerr;
        logic        fe;
        logic [9:0]  fc;
        logic [1:0]  fin;      // out_finish, sd_write_done
        logic [3:0]  e_state;
        logic [3:0]  e_flags;  // com_enable, out_enable, busy, done
        logic [3:0]  e_err;
        logic [15:0] e_bytes;
    } vec_t;

    vec_t vec [23];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] st, input logic [3:0] flags,
                              input logic [3:0] err, input logic [15:0] bytes);
        chk({name, ".state"}, {12'd0, state_code}, {12'd0, st});
        chk({name, ".flags"}, {12'd0, com_enable, out_enable, busy, done}, {12'd0, flags});
        chk({name, ".err"},   {12'd0, err_code}, {12'd0, err});
        chk({name, ".bytes"}, byte_count, bytes);
        $display("%-14s state=%0d com=%b out=%b busy=%b done=%b err=%h bytes=%0d",
                 name, state_code, com_enable, out_enable, busy, done, err_code, byte_count);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0; abort = 1'b0; sd_init_done = 1'b0; com_finish = 1'b0;
        com_error = 4'h0; fifo_empty = 1'b1; fifo_count = 10'd0;
        out_finish = 1'b0; sd_write_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check_outs("after_reset", 4'd0, 4'b0000, 4'h0, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{4'b1000, 4'h0, 1'b1, 10'd0, 2'b00, 4'd1,  4'b0010, 4'h0, 16'd0};
        vec[1]  = '{4'b0000, 4'h0, 1'b1, 10'd0, 2'b00, 4'd1,  4'b0010, 4'h0, 16'd0};
        vec[2]  = '{4'b0010, 4'h0, 1'b1, 10'd0, 2'b00, 4'd2,  4'b1010, 4'h0, 16'd0};
        vec[3]  = '{4'b1010, 4'h0, 1'b0, 10'd3, 2'b00, 4'd2,  4'b1010, 4'h0, 16'd0};
        vec[4]  = '{4'b0001, 4'h0, 1'b0, 10'd5, 2'b00, 4'd3,  4'b0110, 4'h0, 16'd0};
        vec[5]  = '{4'b0000, 4'h0, 1'b0, 10'd4, 2'b00, 4'd3,  4'b0110, 4'h0, 16'd1};
        vec[6]  = '{4'b0000, 4'h0, 1'b0, 10'd3, 2'b00, 4'd3,  4'b0110, 4'h0, 16'd2};
        vec[7]  = '{4'b0000, 4'h0, 1'b0, 10'd3, 2'b00, 4'd3,  4'b0110, 4'h0, 16'd2};
        vec[8]  = '{4'b0000, 4'h0, 1'b0, 10'd4, 2'b00, 4'd3,  4'b0110, 4'h0, 16'd2};
        vec[9]  = '{4'b0000, 4'h0, 1'b0, 10'd3, 2'b00, 4'd3,  4'b0110, 4'h0, 16'd3};
        vec[10] = '{4'b0000, 4'h0, 1'b0, 10'd2, 2'b00, 4'd3,  4'b0110, 4'h0, 16'd4};
        vec[11] = '{4'b0000, 4'h0, 1'b0, 10'd1, 2'b00, 4'd3,  4'b0110, 4'h0, 16'd5};
        vec[12] = '{4'b0000, 4'h0, 1'b1, 10'd0, 2'b00, 4'd3,  4'b0110, 4'h0, 16'd6};
        vec[13] = '{4'b0000, 4'h0, 1'b1, 10'd0, 2'b10, 4'd4,  4'b0010, 4'h0, 16'd6};
        vec[14] = '{4'b0000, 4'h0, 1'b1, 10'd0, 2'b00, 4'd4,  4'b0010, 4'h0, 16'd6};
        vec[15] = '{4'b0000, 4'h0, 1'b1, 10'd0, 2'b01, 4'd5,  4'b0001, 4'h0, 16'd6};
        vec[16] = '{4'b0000, 4'h0, 1'b1, 10'd0, 2'b00, 4'd5,  4'b0001, 4'h0, 16'd6};
        vec[17] = '{4'b1000, 4'h0, 1'b1, 10'd0, 2'b00, 4'd1,  4'b0010, 4'h0, 16'd0};
        vec[18] = '{4'b0010, 4'h0, 1'b1, 10'd0, 2'b00, 4'd2,  4'b1010, 4'h0, 16'd0};
        vec[19] = '{4'b0001, 4'h3, 1'b1, 10'd0, 2'b00, 4'd15, 4'b0000, 4'h3, 16'd0};
        vec[20] = '{4'b0000, 4'h0, 1'b1, 10'd0, 2'b00, 4'd15, 4'b0000, 4'h3, 16'd0};
        vec[21] = '{4'b1000, 4'h0, 1'b1, 10'd0, 2'b00, 4'd1,  4'b0010, 4'h0, 16'd0};
        vec[22] = '{4'b0100, 4'h0, 1'b1, 10'd0, 2'b00, 4'd0,  4'b0000, 4'h0, 16'd0};

        clear_inputs();
        step();
        check_outs("reset_hold", 4'd0, 4'b0000, 4'h0, 16'd0);
        do_reset();

        for (int i = 0; i < 23; i++) begin
            {start, abort, sd_init_done, com_finish} = vec[i].ctl;
            com_error  = vec[i].cerr;
            fifo_empty = vec[i].fe;
            fifo_count = vec[i].fc;
            {out_finish, sd_write_done} = vec[i].fin;
            step();
            check_outs($sformatf("vec%0d", i), vec[i].e_state, vec[i].e_flags,
                       vec[i].e_err, vec[i].e_bytes);
        end

        // Full transfer with realistic wait lengths and 8 drained bytes.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        check_outs("full_start", 4'd1, 4'b0010, 4'h0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_outs($sformatf("full_wsd%0d", i), 4'd1, 4'b0010, 4'h0, 16'd0);
        end
        sd_init_done = 1'b1;
        fifo_count = 10'd8;
        fifo_empty = 1'b0;
        step();
        check_outs("full_recv", 4'd2, 4'b1010, 4'h0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            start = (i == 3) || (i == 10);
            step();
            check_outs($sformatf("full_rx%0d", i), 4'd2, 4'b1010, 4'h0, 16'd0);
        end
        start = 1'b0;
        com_finish = 1'b1;
        step();
        com_finish = 1'b0;
        check_outs("full_drain", 4'd3, 4'b0110, 4'h0, 16'd0);
        for (int i = 7; i >= 0; i--) begin
            fifo_count = 10'(i);
            fifo_empty = (i == 0);
            step();
            check_outs($sformatf("full_dr%0d", i), 4'd3, 4'b0110, 4'h0, 16'(8 - i));
        end
        out_finish = 1'b1;
        step();
        out_finish = 1'b0;
        check_outs("full_flush", 4'd4, 4'b0010, 4'h0, 16'd8);
        sd_write_done = 1'b1;
        step();
        sd_write_done = 1'b0;
        check_outs("full_done", 4'd5, 4'b0001, 4'h0, 16'd8);

        // Asynchronous reset in the middle of DRAIN.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        sd_init_done = 1'b1;
        step();
        com_finish = 1'b1;
        step();
        check_outs("rst_in_drain", 4'd3, 4'b0110, 4'h0, 16'd0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("rst_async", 4'd0, 4'b0000, 4'h0, 16'd0);
        step();
        reset = 1'b1;
        step();
        check_outs("rst_release", 4'd0, 4'b0000, 4'h0, 16'd0);

        // Timeout instance: SD never initialises, then RECEIVE stalls.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("tmo_wsd_enter", {12'd0, t_state_code}, 16'd1);
        for (int i = 0; i < 15; i++) step();
        chk("tmo_wsd_15", {12'd0, t_state_code}, 16'd1);
        step();
        chk("tmo_wsd_state", {12'd0, t_state_code}, 16'd15);
        chk("tmo_wsd_err", {12'd0, t_err_code}, 16'h000A);
        chk("tmo_wsd_busy", {15'd0, t_busy}, 16'd0);
        chk("tmo_main_still_wsd", {12'd0, state_code}, 16'd1);
        $display("timeout_wsd    t_state=%0d t_err=%h main_state=%0d", t_state_code, t_err_code, state_code);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("tmo_restart_err", {12'd0, t_err_code}, 16'h0000);
        sd_init_done = 1'b1;
        step();
        chk("tmo_rx_enter", {12'd0, t_state_code}, 16'd2);
        for (int i = 0; i < 15; i++) step();
        chk("tmo_rx_15", {12'd0, t_state_code}, 16'd2);
        step();
        chk("tmo_rx_state", {12'd0, t_state_code}, 16'd15);
        chk("tmo_rx_err", {12'd0, t_err_code}, 16'h000E);
        chk("tmo_rx_com_en", {15'd0, t_com_enable}, 16'd0);
        $display("timeout_rx     t_state=%0d t_err=%h t_com=%b", t_state_code, t_err_code, t_com_enable);

        // Abort coincident with sd_write_done in FLUSH wins.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        sd_init_done = 1'b1;
        step();
        com_finish = 1'b1;
        step();
        com_finish = 1'b0;
        out_finish = 1'b1;
        step();
        out_finish = 1'b0;
        check_outs("abort_flush", 4'd4, 4'b0010, 4'h0, 16'd0);
        abort = 1'b1;
        sd_write_done = 1'b1;
        step();
        abort = 1'b0;
        check_outs("abort_hit", 4'd0, 4'b0000, 4'h0, 16'd0);
        step();
        check_outs("abort_after", 4'd0, 4'b0000, 4'h0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
